alu_seq: RTL and testbench

- Parametrised, registered successor to the processor's combinational 16-bit ALU.
- Performs single-cycle arithmetic, logic and shift ops, plus an iterative shift-add multiply that takes WIDTH cycles.
- Holds the PSR flag register {N,Z,F,L,C} internally and evaluates the branch condition against those stored flags.
- Sits in the execute stage; the controller drives start/op and waits for done.

---
 rtl/alu_seq.sv | 200 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with an internal PSR {N,Z,F,L,C}. Single-cycle arithmetic,
// logic and shift ops, plus an iterative shift-add multiply that takes WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] src,
  input  logic [3:0]       cond,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic [4:0]       flags,
  output logic             cond_true,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_LSH  = 4'd8;
  localparam logic [3:0] OP_ASH  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  // Flag bit positions within the PSR
  localparam int FN = 4;
  localparam int FZ = 3;
  localparam int FF = 2;
  localparam int FL = 1;
  localparam int FC = 0;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [SHW-1:0]   cnt;
  logic             mul_last;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flags;
  logic             alu_we, alu_bad;
  logic [WIDTH-1:0] shamt;
  logic             sh_neg, sh_big;
  logic [SHW-1:0]   sh;

  always_comb begin
    alu_res   = result;
    alu_flags = flags;
    alu_we    = 1'b1;
    alu_bad   = 1'b0;
    sum_ext   = '0;
    // Shift amount is src read as two's complement; the magnitude stays
    // WIDTH bits wide so the most negative value still compares as huge.
    sh_neg    = src[WIDTH-1];
    shamt     = sh_neg ? -src : src;
    sh_big    = (shamt >= W_LIM);
    sh        = shamt[SHW-1:0];
    case (op)
      OP_ADD, OP_ADDC: begin
        sum_ext = {1'b0, dst} + {1'b0, src}
                + ((op == OP_ADDC) ? {{WIDTH{1'b0}}, flags[FC]} : '0);
        alu_res       = sum_ext[WIDTH-1:0];
        alu_flags[FC] = sum_ext[WIDTH];
        alu_flags[FF] = (dst[WIDTH-1] == src[WIDTH-1]) && (sum_ext[WIDTH-1] != dst[WIDTH-1]);
      end
      OP_SUB: begin
        sum_ext       = {1'b0, dst} - {1'b0, src};
        alu_res       = sum_ext[WIDTH-1:0];
        alu_flags[FC] = sum_ext[WIDTH];
        alu_flags[FF] = (dst[WIDTH-1] != src[WIDTH-1]) && (sum_ext[WIDTH-1] != dst[WIDTH-1]);
      end
      OP_CMP: begin
        alu_we        = 1'b0;
        alu_flags[FL] = dst < src;
        alu_flags[FN] = $signed(dst) < $signed(src);
        alu_flags[FZ] = dst == src;
      end
      OP_AND: alu_res = dst & src;
      OP_OR:  alu_res = dst | src;
      OP_XOR: alu_res = dst ^ src;
      OP_MOV: alu_res = src;
      OP_LSH: begin
        if (sh_big)      alu_res = '0;
        else if (sh_neg) alu_res = dst >> sh;
        else             alu_res = dst << sh;
      end
      OP_ASH: begin
        if (!sh_neg)     alu_res = sh_big ? '0 : (dst << sh);
        else if (sh_big) alu_res = {WIDTH{dst[WIDTH-1]}};
        else             alu_res = $signed(dst) >>> sh;
      end
      OP_MUL: alu_we = 1'b0;
      default: begin
        alu_we  = 1'b0;
        alu_bad = 1'b1;
      end
    endcase
  end

  assign mul_last = (cnt == SHW'(WIDTH - 1));
  assign acc_next = mplier[cnt] ? (acc + (mcand << cnt)) : acc;
  assign busy     = (state == S_MUL);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start && op == OP_MUL) state_next = S_MUL;
      S_MUL:  if (mul_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Datapath: single-cycle ops retire from IDLE; a start during MUL is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      flags     <= '0;
      done      <= 1'b0;
      result_we <= 1'b0;
      illegal   <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      done      <= 1'b0;
      result_we <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand  <= dst;
              mplier <= src;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              done      <= 1'b1;
              result_we <= alu_we;
              illegal   <= alu_bad;
              flags     <= alu_flags;
              if (alu_we) result <= alu_res;
            end
          end
        end
        S_MUL: begin
          acc <= acc_next;
          cnt <= cnt + SHW'(1);
          if (mul_last) begin
            result    <= acc_next;
            done      <= 1'b1;
            result_we <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'd0:  cond_true = flags[FZ];
      4'd1:  cond_true = !flags[FZ];
      4'd2:  cond_true = flags[FC];
      4'd3:  cond_true = !flags[FC];
      4'd4:  cond_true = !flags[FL] && !flags[FZ];
      4'd5:  cond_true = flags[FL] || flags[FZ];
      4'd6:  cond_true = !flags[FN] && !flags[FZ];
      4'd7:  cond_true = flags[FN] || flags[FZ];
      4'd8:  cond_true = flags[FF];
      4'd9:  cond_true = !flags[FF];
      4'd10: cond_true = flags[FL];
      4'd11: cond_true = !flags[FL];
      4'd12: cond_true = flags[FN];
      4'd13: cond_true = !flags[FN];
      4'd14: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a table of single-cycle ops with hand-computed
// results/flags/conditions, then multiply, busy-drop and reset-abort sequences.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op, cond;
  logic [15:0] dst, src;
  logic [15:0] result;
  logic        result_we, cond_true, busy, done, illegal;
  logic [4:0]  flags;

  int tests = 0;
  int failures = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .dst(dst), .src(src),
    .cond(cond), .result(result), .result_we(result_we), .flags(flags),
    .cond_true(cond_true), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] dst;
    logic [15:0] src;
    logic [3:0]  cond;
    logic [15:0] exp_res;
    logic        exp_we;
    logic        exp_ill;
    logic [4:0]  exp_flags;
    logic        exp_cond;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Present one request before the next rising edge, sample just after it.
  task automatic applyStimulus(input logic [3:0] o, input logic [15:0] d, input logic [15:0] s);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    dst   = d;
    src   = s;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic runMul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_res,
                        input logic [4:0] exp_flags, input bit intrude);
    int edges;
    int busy_cycles;
    bit got;
    edges = 0;
    busy_cycles = 0;
    got = 0;
    applyStimulus(4'd10, a, b);
    checkOutput("mul_busy_after_start", 32'(busy), 32'd1);
    checkOutput("mul_no_early_done", 32'(done), 32'd0);
    while (!got && edges < 40) begin
      if (busy) busy_cycles++;
      if (done) got = 1;
      else begin
        @(negedge clk);
        if (intrude && edges == 4) begin
          start = 1'b1;
          op    = 4'd0;
          dst   = 16'h0001;
          src   = 16'h0001;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        edges++;
      end
    end
    checkOutput("mul_done_seen", 32'(got), 32'd1);
    checkOutput("mul_done_edge", 32'(edges), 32'd16);
    checkOutput("mul_busy_cycles", 32'(busy_cycles), 32'd16);
    checkOutput("mul_result", 32'(result), 32'(exp_res));
    checkOutput("mul_result_we", 32'(result_we), 32'd1);
    checkOutput("mul_illegal", 32'(illegal), 32'd0);
    checkOutput("mul_flags", 32'(flags), 32'(exp_flags));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int spurious;

    // op, dst, src, cond, result, we, illegal, flags {N,Z,F,L,C}, cond_true
    vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 4'd8,  16'h8000, 1'b1, 1'b0, 5'b00100, 1'b1};
    vecs[1]  = '{4'd1,  16'hFFFF, 16'h0001, 4'd2,  16'h0000, 1'b1, 1'b0, 5'b00001, 1'b1};
    vecs[2]  = '{4'd1,  16'h7FFF, 16'h0000, 4'd8,  16'h8000, 1'b1, 1'b0, 5'b00100, 1'b1};
    vecs[3]  = '{4'd2,  16'h0000, 16'h0001, 4'd3,  16'hFFFF, 1'b1, 1'b0, 5'b00001, 1'b0};
    vecs[4]  = '{4'd3,  16'h0005, 16'hFFFF, 4'd6,  16'hFFFF, 1'b0, 1'b0, 5'b00011, 1'b1};
    vecs[5]  = '{4'd4,  16'h00FF, 16'h0F0F, 4'd10, 16'h000F, 1'b1, 1'b0, 5'b00011, 1'b1};
    vecs[6]  = '{4'd5,  16'h00F0, 16'h0F00, 4'd4,  16'h0FF0, 1'b1, 1'b0, 5'b00011, 1'b0};
    vecs[7]  = '{4'd6,  16'hFFFF, 16'h0F0F, 4'd5,  16'hF0F0, 1'b1, 1'b0, 5'b00011, 1'b1};
    vecs[8]  = '{4'd7,  16'h0000, 16'h1234, 4'd11, 16'h1234, 1'b1, 1'b0, 5'b00011, 1'b0};
    vecs[9]  = '{4'd8,  16'h8001, 16'hFFFF, 4'd14, 16'h4000, 1'b1, 1'b0, 5'b00011, 1'b1};
    vecs[10] = '{4'd9,  16'h8000, 16'hFFF0, 4'd15, 16'hFFFF, 1'b1, 1'b0, 5'b00011, 1'b0};
    vecs[11] = '{4'd8,  16'h0001, 16'h000F, 4'd0,  16'h8000, 1'b1, 1'b0, 5'b00011, 1'b0};
    vecs[12] = '{4'd8,  16'h0001, 16'h0010, 4'd1,  16'h0000, 1'b1, 1'b0, 5'b00011, 1'b1};
    vecs[13] = '{4'd9,  16'h8000, 16'h8000, 4'd9,  16'hFFFF, 1'b1, 1'b0, 5'b00011, 1'b1};
    vecs[14] = '{4'd9,  16'h4000, 16'hFFF0, 4'd13, 16'h0000, 1'b1, 1'b0, 5'b00011, 1'b1};
    vecs[15] = '{4'd9,  16'h0003, 16'h0002, 4'd12, 16'h000C, 1'b1, 1'b0, 5'b00011, 1'b0};
    vecs[16] = '{4'd8,  16'hF000, 16'hFFFC, 4'd7,  16'h0F00, 1'b1, 1'b0, 5'b00011, 1'b0};
    vecs[17] = '{4'd9,  16'hF000, 16'hFFFC, 4'd2,  16'hFF00, 1'b1, 1'b0, 5'b00011, 1'b1};
    vecs[18] = '{4'd12, 16'h1111, 16'h2222, 4'd10, 16'hFF00, 1'b0, 1'b1, 5'b00011, 1'b1};
    vecs[19] = '{4'd3,  16'h8000, 16'h0001, 4'd12, 16'hFF00, 1'b0, 1'b0, 5'b10001, 1'b1};
    vecs[20] = '{4'd3,  16'h1234, 16'h1234, 4'd0,  16'hFF00, 1'b0, 1'b0, 5'b01001, 1'b1};
    vecs[21] = '{4'd2,  16'h8000, 16'h0001, 4'd7,  16'h7FFF, 1'b1, 1'b0, 5'b01100, 1'b1};
    vecs[22] = '{4'd1,  16'h0001, 16'h0001, 4'd13, 16'h0002, 1'b1, 1'b0, 5'b01000, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    op    = 4'd0;
    cond  = 4'd0;
    dst   = '0;
    src   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_flags", 32'(flags), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_we", 32'(result_we), 32'd0);
    checkOutput("reset_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      cond = vecs[i].cond;
      applyStimulus(vecs[i].op, vecs[i].dst, vecs[i].src);
      checkOutput($sformatf("v%0d_done", i), 32'(done), 32'd1);
      checkOutput($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
      checkOutput($sformatf("v%0d_we", i), 32'(result_we), 32'(vecs[i].exp_we));
      checkOutput($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].exp_ill));
      checkOutput($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].exp_flags));
      checkOutput($sformatf("v%0d_cond", i), 32'(cond_true), 32'(vecs[i].exp_cond));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      checkOutput($sformatf("v%0d_we_pulse", i), 32'(result_we), 32'd0);
    end

    // Multiply with an ADD issued mid-flight, then an ADD started in the done cycle.
    runMul(16'h0123, 16'h0010, 16'h1230, 5'b01000, 1'b1);
    applyStimulus(4'd0, 16'h0001, 16'h0002);
    checkOutput("b2b_done", 32'(done), 32'd1);
    checkOutput("b2b_result", 32'(result), 32'h0003);
    checkOutput("b2b_flags", 32'(flags), 32'b01000);
    checkOutput("b2b_busy", 32'(busy), 32'd0);

    runMul(16'hFFFF, 16'hFFFF, 16'h0001, 5'b01000, 1'b0);

    // Reset eight cycles into a multiply discards it.
    applyStimulus(4'd10, 16'h0003, 16'h0005);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_mul_busy", 32'(busy), 32'd0);
    checkOutput("rst_mul_result", 32'(result), 32'd0);
    checkOutput("rst_mul_flags", 32'(flags), 32'd0);
    checkOutput("rst_mul_done", 32'(done), 32'd0);
    reset = 1'b0;
    spurious = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) spurious++;
    end
    checkOutput("rst_mul_no_done", 32'(spurious), 32'd0);
    cond = 4'd3;
    applyStimulus(4'd0, 16'h0002, 16'h0003);
    checkOutput("post_rst_done", 32'(done), 32'd1);
    checkOutput("post_rst_result", 32'(result), 32'h0005);
    checkOutput("post_rst_flags", 32'(flags), 32'd0);
    checkOutput("post_rst_cond", 32'(cond_true), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
